beat_tempo_tracker: RTL

BEAT_TEMPO_TRACKER -- requirements
Module: beat_tempo_tracker

---
 rtl/beat_tempo_tracker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/beat_tempo_tracker.sv
// Beat tempo tracker: turns accepted beat intervals into a BPM estimate with a serial restoring divider.
// Optional feature: define BEAT_TIMEOUT_EN to drop tempo and history after TIMEOUT_FRAMES frames without a beat.
module beat_tempo_tracker #(
   parameter int MIN_INTERVAL   = 12,
   parameter int MAX_INTERVAL   = 63,
   parameter int BPM_NUM        = 2812,
   parameter int HIST_DEPTH     = 8,
   parameter int TIMEOUT_FRAMES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flux_valid,
   input  logic       beat_valid,
   output logic [8:0] bpm,
   output logic       bpm_valid,
   output logic       locked,
   output logic [7:0] last_interval,
   output logic       beat_accept,
   output logic       interval_reject,
   output logic       busy,
   output logic [1:0] dbg_state
);

   localparam int PTR_W    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int CNT_W    = $clog2(HIST_DEPTH + 1);
   localparam int DIVIDEND = BPM_NUM * HIST_DEPTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               w_load;

   logic               r_flux_prev;
   logic               r_armed;
   logic [7:0]         r_frames_since;
   logic [7:0]         r_hist [HIST_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [10:0]        r_sum;
   logic               r_locked;
   logic [7:0]         r_last_interval;
   logic               r_beat_accept;
   logic               r_interval_reject;

   logic [19:0]        r_dq;
   logic [10:0]        r_rem;
   logic [10:0]        r_divisor;
   logic [4:0]         r_cnt;
   logic               r_pending;
   logic [8:0]         r_bpm;
   logic               r_bpm_valid;

   logic               w_frame;
   logic               w_beat;
   logic               w_timeout;
   logic [8:0]         w_interval;
   logic [7:0]         w_fs_inc;
   logic [10:0]        w_sum_new;
   logic [11:0]        w_trial;
   logic [8:0]         w_quot_sat;

   assign w_frame    = flux_valid & ~r_flux_prev;
   assign w_beat     = w_frame & beat_valid;
   assign w_interval = {1'b0, r_frames_since} + 9'd1;
   assign w_fs_inc   = (r_frames_since == 8'hFF) ? 8'hFF : r_frames_since + 8'd1;
   assign w_sum_new  = r_sum - {3'b000, r_hist[r_wr_ptr]} + {3'b000, w_interval[7:0]};
   assign w_trial    = {r_rem, r_dq[19]};
   assign w_quot_sat = (r_dq > 20'd511) ? 9'd511 : r_dq[8:0];

`ifdef BEAT_TIMEOUT_EN
   assign w_timeout = r_armed && (r_frames_since == 8'(TIMEOUT_FRAMES));
`else
   assign w_timeout = 1'b0;
`endif

   // Beat qualification, interval history and running sum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flux_prev       <= 1'b0;
         r_armed           <= 1'b0;
         r_frames_since    <= '0;
         for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
         r_wr_ptr          <= '0;
         r_count           <= '0;
         r_sum             <= '0;
         r_locked          <= 1'b0;
         r_last_interval   <= '0;
         r_beat_accept     <= 1'b0;
         r_interval_reject <= 1'b0;
      end else begin
         r_flux_prev       <= flux_valid;
         r_beat_accept     <= 1'b0;
         r_interval_reject <= 1'b0;
         if (w_timeout) begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_sum    <= '0;
            r_locked <= 1'b0;
            r_armed  <= 1'b0;
         end else if (w_frame) begin
            if (!w_beat) begin
               r_frames_since <= w_fs_inc;
            end else if (!r_armed) begin
               r_armed        <= 1'b1;
               r_frames_since <= '0;
            end else if (w_interval < 9'(MIN_INTERVAL)) begin
               r_frames_since <= w_fs_inc;
            end else if (w_interval > 9'(MAX_INTERVAL)) begin
               r_interval_reject <= 1'b1;
               r_frames_since    <= '0;
            end else begin
               r_hist[r_wr_ptr] <= w_interval[7:0];
               r_wr_ptr         <= (r_wr_ptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
               r_sum            <= w_sum_new;
               r_last_interval  <= w_interval[7:0];
               r_beat_accept    <= 1'b1;
               r_frames_since   <= '0;
               if (!r_locked) begin
                  r_count <= r_count + 1'b1;
                  if (r_count == CNT_W'(HIST_DEPTH - 1)) r_locked <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // A new accept during a divide is folded into one recompute from the latest sum.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_beat_accept && r_locked && (r_sum != 11'd0)) begin
               w_state_next = S_DIV;
               w_load       = 1'b1;
            end
         end
         S_DIV: begin
            if (r_cnt == 5'd19) w_state_next = S_DONE;
         end
         S_DONE: begin
            if ((r_pending || r_beat_accept) && r_locked && (r_sum != 11'd0)) begin
               w_state_next = S_DIV;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_timeout) begin
         w_state_next = S_IDLE;
         w_load       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dq        <= '0;
         r_rem       <= '0;
         r_divisor   <= '0;
         r_cnt       <= '0;
         r_pending   <= 1'b0;
         r_bpm       <= '0;
         r_bpm_valid <= 1'b0;
      end else begin
         r_bpm_valid <= 1'b0;
         if (w_timeout) begin
            r_pending <= 1'b0;
            r_bpm     <= '0;
         end else begin
            if (w_load) begin
               r_divisor <= r_sum;
               r_dq      <= 20'(DIVIDEND);
               r_rem     <= '0;
               r_cnt     <= '0;
               r_pending <= 1'b0;
            end else if (r_state == S_DIV) begin
               if (w_trial >= {1'b0, r_divisor}) begin
                  r_rem <= 11'(w_trial - {1'b0, r_divisor});
                  r_dq  <= {r_dq[18:0], 1'b1};
               end else begin
                  r_rem <= w_trial[10:0];
                  r_dq  <= {r_dq[18:0], 1'b0};
               end
               r_cnt <= r_cnt + 5'd1;
               if (r_beat_accept) r_pending <= 1'b1;
            end
            if (r_state == S_DONE) begin
               r_bpm       <= w_quot_sat;
               r_bpm_valid <= 1'b1;
            end
         end
      end
   end

   assign bpm             = r_bpm;
   assign bpm_valid       = r_bpm_valid;
   assign locked          = r_locked;
   assign last_interval   = r_last_interval;
   assign beat_accept     = r_beat_accept;
   assign interval_reject = r_interval_reject;
   assign busy            = (r_state != S_IDLE);
   assign dbg_state       = r_state;

endmodule
